// File: rtl/alu_arb_pkg.sv
// Shared defaults and types for the round-robin ALU pipeline arbiter.
package alu_arb_pkg;

   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_DATA_W    = 10;
   localparam int unsigned DEF_TAG_DEPTH = 8;
   localparam int unsigned REQ_ID_W      = $clog2(DEF_NUM_REQ);

   typedef logic [REQ_ID_W-1:0]   req_id_t;
   typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Requester, pipeline and response signals of the arbiter; slave = arbiter side.
interface alu_rr_arbiter_if import alu_arb_pkg::*; #(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_wvalid;
   logic [NUM_REQ-1:0]        req_wready;
   logic [DATA_W-1:0]         m_wdata;
   logic                      m_wvalid;
   logic                      m_wready;
   logic [DATA_W-1:0]         s_rdata;
   logic                      s_rvalid;
   logic                      s_rready;
   logic [DATA_W-1:0]         rsp_rdata;
   logic [NUM_REQ-1:0]        rsp_rvalid;
   logic [NUM_REQ-1:0]        rsp_rready;
   logic                      err_orphan;

   modport slave (
      input  req_wdata, req_wvalid, m_wready, s_rdata, s_rvalid, rsp_rready,
      output req_wready, m_wdata, m_wvalid, s_rready, rsp_rdata, rsp_rvalid, err_orphan
   );

   modport master (
      output req_wdata, req_wvalid, m_wready, s_rdata, s_rvalid, rsp_rready,
      input  req_wready, m_wdata, m_wvalid, s_rready, rsp_rdata, rsp_rvalid, err_orphan
   );

endinterface

// File: rtl/alu_tag_fifo.sv
// In-order FIFO of requester IDs for operations currently inside the pipeline.
module alu_tag_fifo import alu_arb_pkg::*; #(
   parameter int unsigned DEPTH = DEF_TAG_DEPTH,
   parameter int unsigned ID_W  = REQ_ID_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [ID_W-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [ID_W-1:0] mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Extra pointer MSB distinguishes full from empty when addresses match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin issue of requester words into the shared ALU pipeline, with
// in-order routing of results back to the issuing requester.
module alu_rr_arbiter import alu_arb_pkg::*; #(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH
) (
   input logic             clk,
   input logic             reset,
   alu_rr_arbiter_if.slave bus
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   head;
   logic [DATA_W-1:0] win_word;
   logic [DATA_W-1:0] m_wdata_q;
   logic              m_wvalid_q;
   logic              err_q;
   logic              found;
   logic              slot_free;
   logic              capture;
   logic              tag_full;
   logic              tag_empty;
   logic              s_ready;

   // Priority search: requesters above last_grant first, then wrap to the rest.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      win_word = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req_wvalid[i] && (ID_W'(i) > last_grant)) begin
            found    = 1'b1;
            winner   = ID_W'(i);
            win_word = bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req_wvalid[i] && (ID_W'(i) <= last_grant)) begin
            found    = 1'b1;
            winner   = ID_W'(i);
            win_word = bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign slot_free = !m_wvalid_q || bus.m_wready;
   assign capture   = slot_free && !tag_full && found;
   assign s_ready   = bus.rsp_rready[head] && !tag_empty;

   assign bus.req_wready = capture ? (NUM_REQ'(1) << winner) : '0;
   assign bus.m_wdata    = m_wdata_q;
   assign bus.m_wvalid   = m_wvalid_q;
   assign bus.s_rready   = s_ready;
   assign bus.rsp_rdata  = bus.s_rdata;
   assign bus.rsp_rvalid = (bus.s_rvalid && !tag_empty) ? (NUM_REQ'(1) << head) : '0;
   assign bus.err_orphan = err_q;

   // Issue slot, grant pointer and sticky orphan-result flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_wvalid_q <= 1'b0;
         m_wdata_q  <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         err_q      <= 1'b0;
      end else begin
         if (capture) begin
            m_wvalid_q <= 1'b1;
            m_wdata_q  <= win_word;
            last_grant <= winner;
         end else if (slot_free) begin
            m_wvalid_q <= 1'b0;
         end
         if (bus.s_rvalid && tag_empty) err_q <= 1'b1;
      end
   end

   alu_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .ID_W  (ID_W)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (capture),
      .push_id (winner),
      .pop     (bus.s_rvalid && s_ready),
      .full    (tag_full),
      .empty   (tag_empty),
      .head    (head)
   );

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: grant-order table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_alu_rr_arbiter;
   import alu_arb_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 10;
   localparam int unsigned DEPTH = 8;

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  ready;
      logic [DW-1:0] word;
   } gvec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   alu_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_wvalid = '0;
      bus.req_wdata  = '0;
      bus.m_wready   = 1'b1;
      bus.s_rvalid   = 1'b0;
      bus.s_rdata    = '0;
      bus.rsp_rready = '1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_word(input int unsigned i, input logic [DW-1:0] w);
      bus.req_wdata[i*DW +: DW] = w;
   endtask

   gvec_t tbl[10];
   int    exp_tags[$];
   int    tag_q[$];
   int    lg, w, c, steps;
   logic  mv, err, slot_free, cap, hs;
   logic [DW-1:0] md;
   logic [N-1:0]  exp_rdy, exp_rsp;

   initial begin
      tbl[0] = '{4'b1111, 4'b0001, 10'h3A0};
      tbl[1] = '{4'b1111, 4'b0010, 10'h3A1};
      tbl[2] = '{4'b1111, 4'b0100, 10'h3A2};
      tbl[3] = '{4'b1111, 4'b1000, 10'h3A3};
      tbl[4] = '{4'b1111, 4'b0001, 10'h3A0};
      tbl[5] = '{4'b1111, 4'b0010, 10'h3A1};
      tbl[6] = '{4'b1001, 4'b1000, 10'h3A3};
      tbl[7] = '{4'b0000, 4'b0000, 10'h000};
      tbl[8] = '{4'b0110, 4'b0010, 10'h3A1};
      tbl[9] = '{4'b0001, 4'b0000, 10'h000};   // eight tags outstanding: full

      // Reset values, then a single op from requester 0 and its result.
      do_reset();
      chk("rst_req_wready", 32'(bus.req_wready), 32'h0);
      chk("rst_m_wvalid",   32'(bus.m_wvalid),   32'h0);
      chk("rst_m_wdata",    32'(bus.m_wdata),    32'h0);
      chk("rst_rsp_rvalid", 32'(bus.rsp_rvalid), 32'h0);
      chk("rst_s_rready",   32'(bus.s_rready),   32'h0);
      chk("rst_err_orphan", 32'(bus.err_orphan), 32'h0);
      set_word(0, 10'h005);
      bus.req_wvalid = 4'b0001;
      #4 chk("t1_req_wready", 32'(bus.req_wready), 32'h1);
      tick();
      bus.req_wvalid = '0;
      #4 chk("t1_m_wvalid", 32'(bus.m_wvalid), 32'h1);
      chk("t1_m_wdata", 32'(bus.m_wdata), 32'h005);
      tick();
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 10'h00A;
      #4 chk("t1_rsp_rvalid", 32'(bus.rsp_rvalid), 32'h1);
      chk("t1_rsp_rdata", 32'(bus.rsp_rdata), 32'h00A);
      chk("t1_s_rready", 32'(bus.s_rready), 32'h1);
      tick();
      bus.s_rvalid = 1'b0;

      // Grant-order table from reset with the pipeline always ready.
      do_reset();
      for (int unsigned i = 0; i < N; i++) set_word(i, DW'(10'h3A0 + i));
      foreach (tbl[r]) begin
         bus.req_wvalid = tbl[r].valid;
         #4 chk($sformatf("tbl%0d_req_wready", r), 32'(bus.req_wready), 32'(tbl[r].ready));
         tick();
         chk($sformatf("tbl%0d_m_wvalid", r), 32'(bus.m_wvalid), 32'(tbl[r].ready != '0));
         if (tbl[r].ready != '0) begin
            chk($sformatf("tbl%0d_m_wdata", r), 32'(bus.m_wdata), 32'(tbl[r].word));
            for (int j = 0; j < int'(N); j++) if (tbl[r].ready[j]) exp_tags.push_back(j);
         end
      end
      // Full: a pop this cycle does not allow a capture; next cycle it does.
      bus.req_wvalid = 4'b0001;
      bus.s_rvalid   = 1'b1;
      #4 chk("full_pop_req_wready", 32'(bus.req_wready), 32'h0);
      chk("full_pop_s_rready", 32'(bus.s_rready), 32'h1);
      chk("full_pop_rsp_rvalid", 32'(bus.rsp_rvalid), 32'(4'b0001));
      tick();
      void'(exp_tags.pop_front());
      bus.s_rvalid = 1'b0;
      #4 chk("after_pop_req_wready", 32'(bus.req_wready), 32'(4'b0001));
      tick();
      exp_tags.push_back(0);
      bus.req_wvalid = '0;
      // Drain: results return to the issuers in issue order.
      steps = 0;
      while (exp_tags.size() > 0 && steps < 20) begin
         bus.s_rvalid = 1'b1;
         bus.s_rdata  = DW'(steps);
         #4 chk($sformatf("drain%0d_rsp_rvalid", steps), 32'(bus.rsp_rvalid),
                32'(4'b0001 << exp_tags[0]));
         chk($sformatf("drain%0d_s_rready", steps), 32'(bus.s_rready), 32'h1);
         tick();
         void'(exp_tags.pop_front());
         steps++;
      end
      bus.s_rvalid = 1'b0;
      #4 chk("drain_err_orphan", 32'(bus.err_orphan), 32'h0);
      tick();

      // Pipeline stall: slot held stable and no grants for 5 cycles.
      do_reset();
      set_word(1, 10'h155);
      bus.req_wvalid = 4'b0010;
      #4 chk("stall_first_req_wready", 32'(bus.req_wready), 32'(4'b0010));
      tick();
      set_word(0, 10'h010); set_word(1, 10'h011); set_word(2, 10'h012); set_word(3, 10'h013);
      bus.req_wvalid = 4'b1111;
      bus.m_wready   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #4 chk($sformatf("stall%0d_req_wready", k), 32'(bus.req_wready), 32'h0);
         chk($sformatf("stall%0d_m_wvalid", k), 32'(bus.m_wvalid), 32'h1);
         chk($sformatf("stall%0d_m_wdata", k), 32'(bus.m_wdata), 32'h155);
         tick();
      end
      bus.m_wready = 1'b1;
      #4 chk("stall_release_req_wready", 32'(bus.req_wready), 32'(4'b0100));
      tick();
      bus.req_wvalid = '0;
      chk("stall_release_m_wdata", 32'(bus.m_wdata), 32'h012);

      // Backpressured result for requester 2, then an orphan result.
      do_reset();
      set_word(2, 10'h0AB);
      bus.req_wvalid = 4'b0100;
      tick();
      bus.req_wvalid = '0;
      tick();
      bus.s_rvalid   = 1'b1;
      bus.s_rdata    = 10'h123;
      bus.rsp_rready = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         #4 chk($sformatf("hold%0d_s_rready", k), 32'(bus.s_rready), 32'h0);
         chk($sformatf("hold%0d_rsp_rvalid", k), 32'(bus.rsp_rvalid), 32'(4'b0100));
         tick();
      end
      bus.rsp_rready = 4'b1111;
      #4 chk("hold_release_s_rready", 32'(bus.s_rready), 32'h1);
      tick();
      #4 chk("orphan_s_rready", 32'(bus.s_rready), 32'h0);
      chk("orphan_rsp_rvalid", 32'(bus.rsp_rvalid), 32'h0);
      chk("orphan_err_before", 32'(bus.err_orphan), 32'h0);
      tick();
      bus.s_rvalid = 1'b0;
      chk("orphan_err_set", 32'(bus.err_orphan), 32'h1);
      tick(); tick(); tick();
      chk("orphan_err_sticky", 32'(bus.err_orphan), 32'h1);
      do_reset();
      chk("orphan_err_cleared", 32'(bus.err_orphan), 32'h0);

      // Randomized traffic against a queue-based model of the rules.
      do_reset();
      lg  = int'(N) - 1;
      mv  = 1'b0;
      md  = '0;
      err = 1'b0;
      tag_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.req_wvalid = N'($urandom_range(0, 15));
         bus.req_wdata  = (N*DW)'({$urandom(), $urandom()});
         bus.m_wready   = ($urandom_range(0, 3) != 0);
         bus.s_rvalid   = ($urandom_range(0, 99) < (((cyc / 100) % 2) != 0 ? 20 : 70));
         bus.s_rdata    = DW'($urandom());
         bus.rsp_rready = N'($urandom_range(0, 15));
         #4;
         slot_free = !mv || bus.m_wready;
         w = -1;
         for (int k = 1; k <= int'(N); k++) begin
            c = (lg + k) % int'(N);
            if (w < 0 && bus.req_wvalid[c]) w = c;
         end
         cap     = slot_free && (tag_q.size() < int'(DEPTH)) && (w >= 0);
         exp_rdy = cap ? N'(1 << w) : '0;
         exp_rsp = (bus.s_rvalid && tag_q.size() > 0) ? N'(1 << tag_q[0]) : '0;
         hs      = bus.s_rvalid && (tag_q.size() > 0) && bus.rsp_rready[tag_q[0]];
         chk("rnd_req_wready", 32'(bus.req_wready), 32'(exp_rdy));
         chk("rnd_m_wvalid",   32'(bus.m_wvalid),   32'(mv));
         if (mv) chk("rnd_m_wdata", 32'(bus.m_wdata), 32'(md));
         chk("rnd_rsp_rvalid", 32'(bus.rsp_rvalid), 32'(exp_rsp));
         chk("rnd_s_rready",   32'(bus.s_rready),   32'((tag_q.size() > 0) && bus.rsp_rready[tag_q[0]]));
         chk("rnd_rsp_rdata",  32'(bus.rsp_rdata),  32'(bus.s_rdata));
         chk("rnd_err_orphan", 32'(bus.err_orphan), 32'(err));
         if (bus.s_rvalid && tag_q.size() == 0) err = 1'b1;
         if (hs) void'(tag_q.pop_front());
         if (cap) begin
            tag_q.push_back(w);
            mv = 1'b1;
            md = bus.req_wdata[w*DW +: DW];
            lg = w;
         end else if (slot_free) begin
            mv = 1'b0;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter that shares the single fifo→ALU→fifo pipeline among NUM_REQ requesters. It accepts 10-bit operation words from each requester's write channel and issues them one at a time into the pipeline input. It records the issuing requester's ID in an in-order tag FIFO. Each result leaving the pipeline is routed back to the requester that issued it, relying on the pipeline's strict in-order behaviour.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 10, operation/result word width (matches pipeline)
- TAG_DEPTH, 8, max in-flight operations (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_wdata  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- req_wvalid  in  NUM_REQ  per-requester valid
- req_wready  out  NUM_REQ  per-requester ready (one-hot or zero)
- m_wdata  out  DATA_W  word to pipeline input
- m_wvalid  out  1  pipeline input valid
- m_wready  in  1  pipeline input ready
- s_rdata  in  DATA_W  pipeline result
- s_rvalid  in  1  pipeline result valid
- s_rready  out  1  pipeline result ready
- rsp_rdata  out  DATA_W  result, broadcast to all requesters (= s_rdata)
- rsp_rvalid  out  NUM_REQ  per-requester result valid (one-hot or zero)
- rsp_rready  in  NUM_REQ  per-requester result ready
- err_orphan  out  1  sticky: result arrived with no outstanding tag

## Operation
- Issue slot: one registered output stage (m_wdata, m_wvalid, slot_id).
- Slot "free" = !m_wvalid || m_wready.
- Capture condition: slot free && tag FIFO not full && any req_wvalid.
- Winner is the first requester with req_wvalid, searching from (last_grant+1) mod NUM_REQ upward.
- req_wready[winner]=1 only when the capture condition holds. All other bits are 0.
- On capture:
  - m_wdata ← winner's word; m_wvalid ← 1.
  - Push winner ID into the tag FIFO; last_grant ← winner.
- Slot free, no capture: m_wvalid ← 0.
- m_wvalid && !m_wready: m_wdata is held stable and no capture occurs.
- Tag FIFO full: no capture, even if a pop happens the same cycle.
- Response routing:
  - head = tag FIFO head ID.
  - rsp_rvalid[head] = s_rvalid && !tag_empty.
  - s_rready = rsp_rready[head] && !tag_empty.
  - A handshake on s pops the tag.
- s_rvalid with tag_empty: s_rready=0, err_orphan←1. err_orphan clears only on reset.
- Push and pop in the same cycle (not full): occupancy is unchanged.
- Data is opaque; no inspection of opcode/operand fields.

## Timing
- Reset values:
  - req_wready=0, m_wvalid=0, m_wdata=0.
  - rsp_rvalid=0, s_rready=0, err_orphan=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Tag FIFO empty.
- Reset mid-operation discards in-flight tags. The pipeline is reset on the same reset.
- Latency: requester handshake at cycle N → m_wvalid at N+1. Back-to-back issue at one word/cycle when m_wready stays high.
- Response path is combinational (zero added latency). rsp_rvalid/s_rready depend on s_rvalid/rsp_rready in the same cycle.
- Fairness: a continuously requesting requester is granted within NUM_REQ captures.

## Structure
- Package alu_arb_pkg:
  - DATA_W and NUM_REQ defaults.
  - REQ_ID_W = $clog2(NUM_REQ).
  - typedef logic [REQ_ID_W-1:0] req_id_t.
  - typedef logic [DATA_W-1:0] word_t.
- Sub-module alu_tag_fifo:
  - Synchronous FIFO of req_id_t, depth TAG_DEPTH.
  - Ports: push/pop/full/empty/head.
  - Pointers are one bit wider than the address, for full/empty.
- Round-robin priority search is inline in alu_rr_arbiter.

## Test plan
- Reset, then req0 sends 10'h005 with m_wready=1 → m_wvalid at the next cycle with m_wdata=10'h005. Pipeline returns 10'h00A → rsp_rvalid=4'b0001, rsp_rdata=10'h00A.
- All four requesters valid continuously, m_wready=1 → grant order 0,1,2,3,0,1. Results route back one-hot in the same order.
- m_wready held low 5 cycles with m_wvalid=1 → m_wdata stable and req_wready=0 for all 5 cycles. Grant resumes on release.
- Issue 8 ops with no results returned (TAG_DEPTH=8) → req_wready=0 on the 9th. After one result handshake, the 9th is accepted the following cycle.
- Result for requester 2 with rsp_rready[2]=0 for 3 cycles → s_rready=0, rsp_rvalid=4'b0100 held. The tag pops on the cycle rsp_rready[2]=1.
- s_rvalid=1 after reset with no issue → s_rready=0, err_orphan=1, held until reset.
